// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle unsigned multiply/divide sequencer that time-shares the external
// 24-bit combinational ALU; results land in Hi/Lo for the mfhi/mflo path.
module alu_muldiv_sequencer #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned CNT_W = 5
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic             AluBNegate,
  output logic [1:0]       AluOp,
  input  logic [WIDTH-1:0] AluResult,
  input  logic             AluCarryOut
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [1:0]       OP_AND   = 2'b00;
  localparam logic [1:0]       OP_ADD   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             divzero_q, divzero_d;
  logic             busy_q, done_q;

  logic [WIDTH-1:0] shifted_rem;
  logic             sub_ok;

  assign shifted_rem = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  // Hi[MSB] set means the shifted remainder already exceeds any divisor.
  assign sub_ok      = AluCarryOut | hi_q[WIDTH-1];

  // State and datapath registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      divzero_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      divzero_q <= divzero_d;
      busy_q    <= (state_d == ITER);
      done_q    <= (state_d == DONE);
    end
  end

  // Next-state and iteration datapath
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    divzero_d = divzero_q;

    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          if (Op && (OpB == '0)) begin
            hi_d      = OpA;
            lo_d      = '1;
            divzero_d = 1'b1;
            state_d   = DONE;
          end else begin
            hi_d      = '0;
            lo_d      = OpA;
            m_d       = OpB;
            cnt_d     = '0;
            op_d      = Op;
            divzero_d = 1'b0;
            state_d   = ITER;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      ITER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q) begin
          if (sub_ok) begin
            hi_d = AluResult;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = shifted_rem;
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          if (lo_q[0]) begin
            hi_d = {AluCarryOut, AluResult[WIDTH-1:1]};
            lo_d = {AluResult[0], lo_q[WIDTH-1:1]};
          end else begin
            hi_d = {1'b0, hi_q[WIDTH-1:1]};
            lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
          end
        end
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ALU drive: the ALU is only borrowed while iterating
  always_comb begin
    AluA       = '0;
    AluB       = '0;
    AluBNegate = 1'b0;
    AluOp      = OP_AND;
    if (state_q == ITER) begin
      AluOp = OP_ADD;
      AluB  = m_q;
      if (op_q) begin
        AluA       = shifted_rem;
        AluBNegate = 1'b1;
      end else begin
        AluA = hi_q;
      end
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DivZero = divzero_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Directed bench for alu_muldiv_sequencer with a behavioural model of the shared ALU.
module tb_alu_muldiv_sequencer;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Start;
  logic        Op;
  logic [23:0] OpA, OpB;
  logic        Busy, Done, DivZero;
  logic [23:0] Hi, Lo, AluA, AluB, AluResult;
  logic        AluBNegate, AluCarryOut;
  logic [1:0]  AluOp;

  int vectors     = 0;
  int miscompares = 0;

  always #5 Clock = ~Clock;

  alu_muldiv_sequencer #(.WIDTH(24), .CNT_W(5)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo),
    .AluA(AluA), .AluB(AluB), .AluBNegate(AluBNegate), .AluOp(AluOp),
    .AluResult(AluResult), .AluCarryOut(AluCarryOut)
  );

  // Shared 24-bit ALU: BNegate inverts B and supplies carry-in
  logic [24:0] alu_sum;
  logic [23:0] alu_b_eff;
  always_comb begin
    alu_b_eff   = AluBNegate ? ~AluB : AluB;
    alu_sum     = {1'b0, AluA} + {1'b0, alu_b_eff} + 25'(AluBNegate);
    AluCarryOut = alu_sum[24];
    case (AluOp)
      2'b00:   AluResult = AluA & alu_b_eff;
      2'b01:   AluResult = AluA | alu_b_eff;
      2'b10:   AluResult = alu_sum[23:0];
      default: AluResult = {23'd0, alu_sum[23]};
    endcase
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op, watch it to completion; optionally poke Start at ITER cycle 'poke'
  task automatic run_op(input string tag, input logic op, input logic [23:0] a,
                        input logic [23:0] b, input int exp_lat,
                        input logic [23:0] exp_hi, input logic [23:0] exp_lo,
                        input logic exp_dz, input int poke);
    int   lat      = 0;
    int   busy_n   = 0;
    logic drive_ok = 1'b1;
    @(negedge Clock);
    Start = 1'b1; Op = op; OpA = a; OpB = b;
    @(posedge Clock);
    #1;
    Start = 1'b0; Op = ~op; OpA = 24'($urandom); OpB = 24'($urandom);
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clock);
      if (i == poke + 1) Start = 1'b0;
      if (Busy) begin
        busy_n++;
        if (AluOp !== 2'b10 || AluBNegate !== op) drive_ok = 1'b0;
      end else if (AluOp !== 2'b00 || AluA !== 24'd0 || AluB !== 24'd0 || AluBNegate !== 1'b0) begin
        drive_ok = 1'b0;
      end
      if (Done) begin
        lat = i;
        break;
      end
      if (i == poke) begin
        Start = 1'b1; Op = 1'b1; OpA = 24'hABCDEF; OpB = 24'd0;
      end
    end
    check({tag, " latency"}, 48'(lat), 48'(exp_lat));
    check({tag, " busy_cycles"}, 48'(busy_n), 48'((exp_lat == 1) ? 0 : 24));
    check({tag, " alu_drive"}, 48'(drive_ok), 48'd1);
    check({tag, " hi"}, 48'(Hi), 48'(exp_hi));
    check({tag, " lo"}, 48'(Lo), 48'(exp_lo));
    check({tag, " divzero"}, 48'(DivZero), 48'(exp_dz));
    @(negedge Clock);
    check({tag, " done_pulse_drop"}, 48'(Done), 48'd0);
    check({tag, " hi_lo_hold"}, {Hi, Lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    Resetn = 1'b0; Start = 1'b0; Op = 1'b0; OpA = '0; OpB = '0;
    repeat (2) @(negedge Clock);
    check("reset busy", 48'(Busy), 48'd0);
    check("reset done", 48'(Done), 48'd0);
    check("reset divzero", 48'(DivZero), 48'd0);
    check("reset hilo", {Hi, Lo}, 48'd0);
    check("reset aluop", 48'({AluOp, AluBNegate}), 48'd0);
    Resetn = 1'b1;

    run_op("mul3x5", 1'b0, 24'h000003, 24'h000005, 25, 24'h000000, 24'h00000F, 1'b0, 0);
    run_op("mulmax", 1'b0, 24'hFFFFFF, 24'hFFFFFF, 25, 24'hFFFFFE, 24'h000001, 1'b0, 0);
    run_op("div100_7", 1'b1, 24'd100, 24'd7, 25, 24'h000002, 24'h00000E, 1'b0, 0);
    run_op("divbig", 1'b1, 24'hFFFFFF, 24'h800001, 25, 24'h7FFFFE, 24'h000001, 1'b0, 0);
    run_op("divzero", 1'b1, 24'h123456, 24'h000000, 1, 24'h123456, 24'hFFFFFF, 1'b1, 0);
    run_op("mul_poke", 1'b0, 24'h001234, 24'h000100, 25, 24'h000000, 24'h123400, 1'b0, 5);

    // Reset in the middle of an operation
    @(negedge Clock);
    Start = 1'b1; Op = 1'b0; OpA = 24'h00ABCD; OpB = 24'h000777;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    repeat (10) @(negedge Clock);
    check("midrst busy_before", 48'(Busy), 48'd1);
    Resetn = 1'b0;
    #1;
    check("midrst busy", 48'(Busy), 48'd0);
    check("midrst done", 48'(Done), 48'd0);
    check("midrst hilo", {Hi, Lo}, 48'd0);
    @(negedge Clock);
    Resetn = 1'b1;

    run_op("mul2x2", 1'b0, 24'd2, 24'd2, 25, 24'h000000, 24'h000004, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
